data_mem_lsu: RTL and testbench



---
 rtl/data_mem_lsu.sv | 135 +++++++++++++
 tb/tb_data_mem_lsu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// Load/store unit with a synchronous-write data array, extended loads and a sticky misalignment fault.
// Optional access counters (LoadCount/StoreCount) are built when DMEM_STATS_EN is defined.
module data_mem_lsu #(
    parameter int ADDR_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MisalignFault,
    output logic [31:0] FaultAddr,
    input  logic        FaultClear
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] LoadCount,
    output logic [31:0] StoreCount
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           offset;
    logic                 ld_misaligned;
    logic                 st_misaligned;
    logic                 st_valid;
    logic                 do_store;
    logic                 fault_trig;
    logic [3:0]           byte_en;
    logic [31:0]          store_data;
    logic [31:0]          rd_word;
    logic [7:0]           rd_byte;
    logic [15:0]          rd_half;

    // Upper address bits are dropped so accesses wrap modulo the array size.
    assign word_idx = ALUResult[ADDR_BITS+1:2];
    assign offset   = ALUResult[1:0];

    always_comb begin
        ld_misaligned = 1'b0;
        case (Funct3)
            3'b001, 3'b101: ld_misaligned = offset[0];
            3'b010:         ld_misaligned = (offset != 2'b00);
            default:        ld_misaligned = 1'b0;
        endcase

        st_valid      = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
        st_misaligned = ((Funct3 == 3'b001) && offset[0]) ||
                        ((Funct3 == 3'b010) && (offset != 2'b00));
        do_store      = MemWrite && st_valid && !st_misaligned;
        fault_trig    = (MemRead && ld_misaligned) || (MemWrite && st_misaligned);

        byte_en    = 4'b0000;
        store_data = WriteData;
        case (Funct3)
            3'b000: begin
                byte_en    = 4'b0001 << offset;
                store_data = {4{WriteData[7:0]}};
            end
            3'b001: begin
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                store_data = {2{WriteData[15:0]}};
            end
            3'b010:  byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        rd_word  = mem[word_idx];
        rd_byte  = rd_word[{offset, 3'b000} +: 8];
        rd_half  = offset[1] ? rd_word[31:16] : rd_word[15:0];
        ReadData = 32'h0;
        if (!ld_misaligned) begin
            case (Funct3)
                3'b000:  ReadData = {{24{rd_byte[7]}}, rd_byte};
                3'b100:  ReadData = {24'h0, rd_byte};
                3'b001:  ReadData = {{16{rd_half[15]}}, rd_half};
                3'b101:  ReadData = {16'h0, rd_half};
                3'b010:  ReadData = rd_word;
                default: ReadData = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
            MisalignFault <= 1'b0;
            FaultAddr     <= 32'h0;
        end else begin
            if (do_store) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) begin
                        mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
                    end
                end
            end
            // A new fault overrides a same-cycle clear; otherwise the first address is kept.
            if (fault_trig) begin
                if (!MisalignFault || FaultClear) begin
                    MisalignFault <= 1'b1;
                    FaultAddr     <= ALUResult;
                end
            end else if (FaultClear) begin
                MisalignFault <= 1'b0;
                FaultAddr     <= 32'h0;
            end
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            LoadCount  <= 32'h0;
            StoreCount <= 32'h0;
        end else begin
            if (MemRead && !ld_misaligned && (LoadCount != 32'hFFFF_FFFF)) begin
                LoadCount <= LoadCount + 32'h1;
            end
            if (do_store && (StoreCount != 32'hFFFF_FFFF)) begin
                StoreCount <= StoreCount + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: byte-addressed reference model, per-cycle compare, directed and random traffic.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWrite;
    logic        MemRead;
    logic        FaultClear;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MisalignFault;
    logic [31:0] FaultAddr;
`ifdef DMEM_STATS_EN
    logic [31:0] LoadCount;
    logic [31:0] StoreCount;
`endif

    always #5 clk = ~clk;

    data_mem_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .Funct3       (Funct3),
        .ALUResult    (ALUResult),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .MisalignFault(MisalignFault),
        .FaultAddr    (FaultAddr),
        .FaultClear   (FaultClear)
`ifdef DMEM_STATS_EN
        ,
        .LoadCount    (LoadCount),
        .StoreCount   (StoreCount)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    logic [7:0]  m_mem [256];
    logic        m_flag;
    logic [31:0] m_addr;
    logic [31:0] exp_rd;
    logic [31:0] m_lc;
    logic [31:0] m_sc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] a, input bit is_load);
        bit valid;
        valid = is_load ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        return valid && ((int'(a[7:0]) % acc_size(f3)) != 0);
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] f3, input logic [31:0] a);
        int          base;
        int          size;
        logic [31:0] v;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 32'h0;
        if (misaligned(f3, a, 1'b1)) return 32'h0;
        base = int'(a[7:0]);
        size = acc_size(f3);
        v = 32'h0;
        for (int k = 0; k < size; k++) begin
            v = v | (32'(m_mem[(base + k) % 256]) << (8 * k));
        end
        if (!f3[2] && size < 4 && v[8*size-1]) begin
            v = v | ~((32'h1 << (8 * size)) - 32'h1);
        end
        return v;
    endfunction

    // Applies the effect of the current inputs at a clock edge.
    task automatic model_update();
        bit trig;
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) m_mem[i] = 8'h0;
            m_flag = 1'b0;
            m_addr = 32'h0;
            m_lc   = 32'h0;
            m_sc   = 32'h0;
            return;
        end
        trig = (MemRead && misaligned(Funct3, ALUResult, 1'b1)) ||
               (MemWrite && misaligned(Funct3, ALUResult, 1'b0));
        if (MemRead && !misaligned(Funct3, ALUResult, 1'b1) && m_lc != 32'hFFFF_FFFF) m_lc = m_lc + 1;
        if (MemWrite && (Funct3 inside {3'd0, 3'd1, 3'd2}) && !misaligned(Funct3, ALUResult, 1'b0)) begin
            for (int k = 0; k < acc_size(Funct3); k++) begin
                m_mem[(int'(ALUResult[7:0]) + k) % 256] = WriteData[8*k +: 8];
            end
            if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        end
        if (trig) begin
            if (!m_flag || FaultClear) begin
                m_flag = 1'b1;
                m_addr = ALUResult;
            end
        end else if (FaultClear) begin
            m_flag = 1'b0;
            m_addr = 32'h0;
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic clr);
        MemWrite   = w;
        MemRead    = r;
        Funct3     = f3;
        ALUResult  = a;
        WriteData  = wd;
        FaultClear = clr;
        exp_rd     = model_read(f3, a);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] exp);
        #2;
        check(name, ReadData, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_model", ReadData, exp_rd);
            check("flag_model", {31'h0, MisalignFault}, {31'h0, m_flag});
            check("faddr_model", FaultAddr, m_addr);
`ifdef DMEM_STATS_EN
            check("lcount_model", LoadCount, m_lc);
            check("scount_model", StoreCount, m_sc);
`endif
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 3'b000, 32'h0, 32'h0, 0);
        tick();
        rst_n = 1'b1;

        drive(0, 1, 3'b010, 32'h10, 32'h0, 0);
        chk_en = 1'b1;
        lit("lw_after_reset", 32'h0);
        check("flag_after_reset", {31'h0, MisalignFault}, 32'h0);
        tick();
        drive(1, 0, 3'b010, 32'h10, 32'hDEADBEEF, 0); tick();
        drive(0, 1, 3'b010, 32'h10, 32'h0, 0); lit("lw_deadbeef", 32'hDEADBEEF); tick();

        drive(1, 0, 3'b010, 32'h20, 32'h80FF7F01, 0); tick();
        drive(0, 1, 3'b000, 32'h23, 32'h0, 0); lit("lb_23", 32'hFFFFFF80); tick();
        drive(0, 1, 3'b100, 32'h23, 32'h0, 0); lit("lbu_23", 32'h00000080); tick();
        drive(0, 1, 3'b001, 32'h20, 32'h0, 0); lit("lh_20", 32'h00007F01); tick();
        drive(0, 1, 3'b101, 32'h22, 32'h0, 0); lit("lhu_22", 32'h000080FF); tick();
        drive(0, 1, 3'b001, 32'h22, 32'h0, 0); lit("lh_22", 32'hFFFF80FF); tick();

        drive(1, 0, 3'b010, 32'h30, 32'h11223344, 0); tick();
        drive(1, 0, 3'b000, 32'h31, 32'h000000AB, 0); tick();
        drive(1, 0, 3'b001, 32'h32, 32'h0000CDEF, 0); tick();
        drive(0, 1, 3'b010, 32'h30, 32'h0, 0); lit("partial_store", 32'hCDEFAB44); tick();

        drive(1, 0, 3'b010, 32'h41, 32'hFFFFFFFF, 0); tick();
        check("flag_set", {31'h0, MisalignFault}, 32'h1);
        check("faddr_41", FaultAddr, 32'h41);
        drive(0, 1, 3'b010, 32'h40, 32'h0, 0); lit("word40_unchanged", 32'h0); tick();
        drive(0, 1, 3'b001, 32'h43, 32'h0, 0); lit("lh_misaligned", 32'h0); tick();
        check("faddr_sticky", FaultAddr, 32'h41);

        drive(0, 0, 3'b000, 32'h0, 32'h0, 1); tick();
        check("flag_cleared", {31'h0, MisalignFault}, 32'h0);
        check("faddr_cleared", FaultAddr, 32'h0);
        drive(1, 0, 3'b001, 32'h45, 32'h1234, 1); tick();
        check("flag_collide", {31'h0, MisalignFault}, 32'h1);
        check("faddr_45", FaultAddr, 32'h45);

        drive(1, 0, 3'b010, 32'h100, 32'h5, 0); tick();
        drive(0, 1, 3'b010, 32'h0, 32'h0, 0); lit("wrap_read", 32'h5); tick();
        drive(1, 1, 3'b010, 32'h0, 32'h9, 0); lit("rdw_old", 32'h5); tick();
        drive(0, 1, 3'b010, 32'h0, 32'h0, 0); lit("rdw_new", 32'h9); tick();

        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'h1FF);
            rst_n = ($urandom_range(0, 249) != 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  a, $urandom, 1'($urandom_range(0, 7) == 0));
            tick();
        end
        rst_n = 1'b1;

        chk_en = 1'b0;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
